// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian 32-bit words and drives the CPU instruction-init port.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the program.
module program_loader #(
  parameter int unsigned MAX_WORDS     = 64,
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int unsigned RELEASE_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  // state     | meaning
  // S_IDLE    | after reset, CPU held in reset, waiting for start
  // S_HDR     | receiving the 2-byte big-endian word count
  // S_LOAD    | receiving program words (and the checksum word when enabled)
  // S_RELEASE | last write cycle, then RELEASE_DELAY idle cycles
  // S_DONE    | program loaded, CPU running
  // S_ERR     | load aborted, CPU held in reset
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_RELEASE, S_DONE, S_ERR} state_t;

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        initialize_q, initialize_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [15:0] words_loaded_q, words_loaded_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  hdr_hi_q, hdr_hi_d;
  logic [15:0] n_words_q, n_words_d;
  logic [23:0] word_sr_q, word_sr_d;
  logic [3:0]  rel_cnt_q, rel_cnt_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic        ck_phase_q, ck_phase_d;
  logic [31:0] ck_q, ck_d;
`endif

  logic        xfer;
  logic [31:0] word;
  logic [15:0] hdr_n;
  logic [15:0] wl_inc;

  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    initialize_d   = initialize_q;
    data_d         = data_q;
    addr_d         = addr_q;
    cpu_rst_d      = cpu_rst_q;
    busy_d         = busy_q;
    done_d         = done_q;
    error_d        = error_q;
    words_loaded_d = words_loaded_q;
    byte_cnt_d     = byte_cnt_q;
    hdr_hi_d       = hdr_hi_q;
    n_words_d      = n_words_q;
    word_sr_d      = word_sr_q;
    rel_cnt_d      = rel_cnt_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ck_phase_d     = ck_phase_q;
    ck_d           = ck_q;
`endif
    xfer   = in_valid & in_ready_q;
    word   = {word_sr_q, in_data};
    hdr_n  = {hdr_hi_q, in_data};
    wl_inc = words_loaded_q + 16'd1;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d        = S_HDR;
          in_ready_d     = 1'b1;
          initialize_d   = 1'b1;
          cpu_rst_d      = 1'b1;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
          byte_cnt_d     = 2'd0;
          words_loaded_d = 16'd0;
          data_d         = 32'd0;
          addr_d         = BASE_ADDR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          ck_phase_d     = 1'b0;
          ck_d           = 32'd0;
`endif
        end
      end
      S_HDR: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          hdr_hi_d   = in_data;
          if (byte_cnt_q == 2'd1) begin
            byte_cnt_d = 2'd0;
            n_words_d  = hdr_n;
            if (hdr_n > 16'(MAX_WORDS)) begin
              state_d      = S_ERR;
              error_d      = 1'b1;
              initialize_d = 1'b0;
              in_ready_d   = 1'b0;
              busy_d       = 1'b0;
            end else if (hdr_n == 16'd0) begin
              // nothing to write, so skip the last-word write cycle
              initialize_d = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_d      = S_LOAD;
              ck_phase_d   = 1'b1;
`else
              state_d      = S_RELEASE;
              in_ready_d   = 1'b0;
              rel_cnt_d    = 4'(RELEASE_DELAY);
`endif
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_LOAD: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (ck_phase_q) initialize_d = 1'b0;
`endif
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_sr_d  = {word_sr_q[15:0], in_data};
          if (byte_cnt_q == 2'd3) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (ck_phase_q) begin
              in_ready_d = 1'b0;
              if (word == ck_q) begin
                state_d   = S_RELEASE;
                rel_cnt_d = 4'(RELEASE_DELAY);
              end else begin
                state_d = S_ERR;
                error_d = 1'b1;
                busy_d  = 1'b0;
              end
            end else begin
              data_d         = word;
              addr_d         = BASE_ADDR + {14'd0, words_loaded_q, 2'b00};
              words_loaded_d = wl_inc;
              ck_d           = ck_q ^ word;
              if (wl_inc == n_words_q) ck_phase_d = 1'b1;
            end
`else
            data_d         = word;
            addr_d         = BASE_ADDR + {14'd0, words_loaded_q, 2'b00};
            words_loaded_d = wl_inc;
            if (wl_inc == n_words_q) begin
              state_d    = S_RELEASE;
              in_ready_d = 1'b0;
              rel_cnt_d  = 4'(RELEASE_DELAY);
            end
`endif
          end
        end
      end
      S_RELEASE: begin
        // initialize still high means the final word is being written this cycle
        if (initialize_q) begin
          initialize_d = 1'b0;
        end else if (rel_cnt_q <= 4'd1) begin
          state_d   = S_DONE;
          cpu_rst_d = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else begin
          rel_cnt_d = rel_cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      in_ready_q     <= 1'b0;
      initialize_q   <= 1'b0;
      data_q         <= 32'd0;
      addr_q         <= BASE_ADDR;
      cpu_rst_q      <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= 16'd0;
      byte_cnt_q     <= 2'd0;
      hdr_hi_q       <= 8'd0;
      n_words_q      <= 16'd0;
      word_sr_q      <= 24'd0;
      rel_cnt_q      <= 4'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ck_phase_q     <= 1'b0;
      ck_q           <= 32'd0;
`endif
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      initialize_q   <= initialize_d;
      data_q         <= data_d;
      addr_q         <= addr_d;
      cpu_rst_q      <= cpu_rst_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      words_loaded_q <= words_loaded_d;
      byte_cnt_q     <= byte_cnt_d;
      hdr_hi_q       <= hdr_hi_d;
      n_words_q      <= n_words_d;
      word_sr_q      <= word_sr_d;
      rel_cnt_q      <= rel_cnt_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ck_phase_q     <= ck_phase_d;
      ck_q           <= ck_d;
`endif
    end
  end

  assign in_ready                       = in_ready_q;
  assign initialize                     = initialize_q;
  assign instruction_initialize_data    = data_q;
  assign instruction_initialize_address = addr_q;
  assign cpu_rst                        = cpu_rst_q;
  assign busy                           = busy_q;
  assign done                           = done_q;
  assign error                          = error_q;
  assign words_loaded                   = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: header table plus hand-written load/abort/reset sequences.
`timescale 1ns/1ps
module tb_program_loader;
  localparam int RD = 2;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int REL_LAT = CK ? RD : RD + 1;

  logic        clk, rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, initialize, cpu_rst, busy, done, error;
  logic [31:0] instruction_initialize_data, instruction_initialize_address;
  logic [15:0] words_loaded;

  int tests = 0;
  int failed = 0;

  program_loader #(.MAX_WORDS(64), .BASE_ADDR(32'h0), .RELEASE_DELAY(RD)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .initialize(initialize),
    .instruction_initialize_data(instruction_initialize_data),
    .instruction_initialize_address(instruction_initialize_address),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU instruction memory model and the sequence of distinct write addresses
  logic [31:0] mem [0:63];
  logic [31:0] addr_log [$];
  always @(posedge clk) begin
    if (rst && initialize) begin
      mem[instruction_initialize_address[7:2]] = instruction_initialize_data;
      if (addr_log.size() == 0 || addr_log[addr_log.size()-1] != instruction_initialize_address)
        addr_log.push_back(instruction_initialize_address);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    int budget;
    logic acc;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = b;
    budget = 0;
    acc = 1'b0;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = in_ready;
      step();
      budget++;
    end
    if (!acc) begin
      tests++;
      failed++;
      $display("FAIL send_byte_timeout: got in_ready=0 for %0d cycles, want acceptance", budget);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    send_byte(w[31:24], maxgap);
    send_byte(w[23:16], maxgap);
    send_byte(w[15:8],  maxgap);
    send_byte(w[7:0],   maxgap);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[15:8], 0);
    send_byte(n[7:0], 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    addr_log.delete();
  endtask

  task automatic wait_end();
    int cyc;
    cyc = 0;
    while (!(done || error) && cyc < 100) begin
      step();
      cyc++;
    end
    if (cyc >= 100) begin
      tests++;
      failed++;
      $display("FAIL wait_end_timeout: got no done/error after %0d cycles, want one", cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   {31'd0, in_ready}, 32'd0);
    check({tag, "_initialize"}, {31'd0, initialize}, 32'd0);
    check({tag, "_data"},       instruction_initialize_data, 32'd0);
    check({tag, "_addr"},       instruction_initialize_address, 32'd0);
    check({tag, "_cpu_rst"},    {31'd0, cpu_rst}, 32'd1);
    check({tag, "_busy"},       {31'd0, busy}, 32'd0);
    check({tag, "_done"},       {31'd0, done}, 32'd0);
    check({tag, "_error"},      {31'd0, error}, 32'd0);
    check({tag, "_words"},      {16'd0, words_loaded}, 32'd0);
  endtask

  function automatic logic [31:0] pat(input int v, input int j);
    return {8'(v + 1), 8'(j), 8'(~j), 8'(v * 7 + 3)};
  endfunction

  typedef struct {
    logic [15:0] n;
    bit          exp_err;
    logic [15:0] exp_wl;
  } vec_t;

  initial begin
    vec_t        vecs [7];
    logic [31:0] ck;
    logic [31:0] w;
    int          lat;
    int          init_cycles;

    vecs[0] = '{16'd0,     1'b0, 16'd0};
    vecs[1] = '{16'd1,     1'b0, 16'd1};
    vecs[2] = '{16'd3,     1'b0, 16'd3};
    vecs[3] = '{16'd64,    1'b0, 16'd64};
    vecs[4] = '{16'h0041,  1'b1, 16'd0};
    vecs[5] = '{16'h0100,  1'b1, 16'd0};
    vecs[6] = '{16'hFFFF,  1'b1, 16'd0};

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    clear_model();
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    // Basic two-word load with exact release timing
    do_start();
    check("start_busy",     {31'd0, busy}, 32'd1);
    check("start_in_ready", {31'd0, in_ready}, 32'd1);
    check("start_init",     {31'd0, initialize}, 32'd1);
    send_hdr(16'h0002);
    send_word(32'h20010001, 0);
    check("w0_data",  instruction_initialize_data, 32'h20010001);
    check("w0_addr",  instruction_initialize_address, 32'd0);
    check("w0_words", {16'd0, words_loaded}, 32'd1);
    send_word(32'h08000006, 0);
    check("w1_data",  instruction_initialize_data, 32'h08000006);
    check("w1_addr",  instruction_initialize_address, 32'd4);
    check("w1_words", {16'd0, words_loaded}, 32'd2);
    if (CK) send_word(32'h20010001 ^ 32'h08000006, 0);
    lat = 0;
    init_cycles = 0;
    while (cpu_rst && lat < 30) begin
      if (initialize) init_cycles++;
      step();
      lat++;
    end
    check("release_latency", lat, REL_LAT);
    check("release_init_cycles", init_cycles, CK ? 0 : 1);
    check("two_done", {31'd0, done}, 32'd1);
    check("two_init_low", {31'd0, initialize}, 32'd0);
    check("two_mem0", mem[0], 32'h20010001);
    check("two_mem1", mem[1], 32'h08000006);
    check("two_addr_log_len", addr_log.size(), 2);

    // Oversized header, then restart
    clear_model();
    do_start();
    send_hdr(16'h0041);
    check("err_error",   {31'd0, error}, 32'd1);
    check("err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("err_ready",   {31'd0, in_ready}, 32'd0);
    check("err_init",    {31'd0, initialize}, 32'd0);
    in_valid = 1'b1; in_data = 8'hAB;
    repeat (3) step();
    in_valid = 1'b0;
    check("err_words", {16'd0, words_loaded}, 32'd0);
    check("err_data",  instruction_initialize_data, 32'd0);
    do_start();
    check("err_clear", {31'd0, error}, 32'd0);
    check("err_restart_busy", {31'd0, busy}, 32'd1);
    send_hdr(16'h0000);
    if (CK) send_word(32'd0, 0);
    wait_end();
    check("zero_done",  {31'd0, done}, 32'd1);
    check("zero_words", {16'd0, words_loaded}, 32'd0);
    check("zero_data",  instruction_initialize_data, 32'd0);

    // Header table
    for (int v = 0; v < 7; v++) begin
      clear_model();
      do_start();
      send_hdr(vecs[v].n);
      ck = 32'd0;
      if (!vecs[v].exp_err) begin
        for (int j = 0; j < int'(vecs[v].n); j++) begin
          w = pat(v, j);
          send_word(w, 0);
          ck ^= w;
        end
        if (CK) send_word(ck, 0);
      end
      wait_end();
      check($sformatf("vec%0d_done", v),    {31'd0, done}, {31'd0, !vecs[v].exp_err});
      check($sformatf("vec%0d_error", v),   {31'd0, error}, {31'd0, vecs[v].exp_err});
      check($sformatf("vec%0d_cpu_rst", v), {31'd0, cpu_rst}, {31'd0, vecs[v].exp_err});
      check($sformatf("vec%0d_ready", v),   {31'd0, in_ready}, 32'd0);
      check($sformatf("vec%0d_busy", v),    {31'd0, busy}, 32'd0);
      check($sformatf("vec%0d_words", v),   {16'd0, words_loaded}, {16'd0, vecs[v].exp_wl});
      if (vecs[v].exp_wl != 16'd0) begin
        check($sformatf("vec%0d_mem_first", v), mem[0], pat(v, 0));
        check($sformatf("vec%0d_mem_last", v), mem[int'(vecs[v].exp_wl) - 1],
              pat(v, int'(vecs[v].exp_wl) - 1));
      end
    end

    // Nine words with random stalls, plus an ignored start mid-load
    clear_model();
    do_start();
    send_hdr(16'd9);
    ck = 32'd0;
    for (int j = 0; j < 9; j++) begin
      w = 32'h20010001 + 32'(j) * 32'h00110003;
      send_word(w, 3);
      ck ^= w;
      if (j == 2) begin
        do_start();
        check("midload_start_busy",  {31'd0, busy}, 32'd1);
        check("midload_start_words", {16'd0, words_loaded}, 32'd3);
      end
    end
    if (CK) send_word(ck, 2);
    wait_end();
    check("nine_done",  {31'd0, done}, 32'd1);
    check("nine_words", {16'd0, words_loaded}, 32'd9);
    for (int j = 0; j < 9; j++)
      check($sformatf("nine_mem%0d", j), mem[j], 32'h20010001 + 32'(j) * 32'h00110003);
    check("nine_addr_log_len", addr_log.size(), 9);
    for (int j = 0; j < 9 && j < addr_log.size(); j++)
      check($sformatf("nine_addr%0d", j), addr_log[j], 32'(4 * j));

    // Reset in the middle of word 3, then a clean load
    clear_model();
    do_start();
    send_hdr(16'd5);
    for (int j = 0; j < 3; j++) send_word(32'hCAFE0000 + 32'(j), 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    rst = 1'b0;
    step();
    check_reset_outputs("midreset");
    rst = 1'b1;
    clear_model();
    do_start();
    send_hdr(16'd2);
    send_word(32'h12345678, 0);
    check("after_reset_w0_data", instruction_initialize_data, 32'h12345678);
    check("after_reset_w0_addr", instruction_initialize_address, 32'd0);
    send_word(32'h9ABCDEF0, 0);
    if (CK) send_word(32'h12345678 ^ 32'h9ABCDEF0, 0);
    wait_end();
    check("after_reset_done", {31'd0, done}, 32'd1);
    check("after_reset_mem0", mem[0], 32'h12345678);
    check("after_reset_mem1", mem[1], 32'h9ABCDEF0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    clear_model();
    do_start();
    send_hdr(16'd2);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    send_word(32'h33333333, 0);
    wait_end();
    check("ck_good_done",  {31'd0, done}, 32'd1);
    check("ck_good_error", {31'd0, error}, 32'd0);
    check("ck_good_mem1",  mem[1], 32'h22222222);
    do_start();
    send_hdr(16'd2);
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    send_word(32'h33333332, 0);
    wait_end();
    check("ck_bad_error",   {31'd0, error}, 32'd1);
    check("ck_bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("ck_bad_done",    {31'd0, done}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
